// File: rtl/soc_system_key_input.sv
// Purpose : Avalon-MM key/switch input port: 2-flop sync, counter debounce, edge capture, IRQ mask.
// Latency : readdata is combinational (0 wait states); a clean input change reaches DATA after 2+DEBOUNCE_CYCLES clocks.
// Backpr. : none; the slave always accepts writes in a single cycle and never stalls the bus.
//
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   address[1:0]           word offset: 0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAPTURE (W1C)
//   chipselect, write_n    write strobe = chipselect & ~write_n
//   writedata[31:0]        write data (only the low WIDTH bits are used)
//   in_port[WIDTH-1:0]     raw asynchronous key inputs
//   readdata[31:0]         read data, unused upper bits are zero
//   irq                    level interrupt, |(edgecapture & irqmask)
module soc_system_key_input #(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   CNT_W           = 16,
  parameter int   EDGE_TYPE       = 1,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_IRQMSK = 2'd2;
  localparam logic [1:0] ADDR_EDGE   = 2'd3;

  // Synchronizer stages
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // Debouncer state
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            accept;

  // Software-visible registers
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] captured;
  logic [WIDTH-1:0] w1c;
  logic             wr_en;

  // Upper writedata bits are architecturally ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect & ~write_n;

  // Per-bit debounce: a differing sample advances the counter, any sample
  // back at the stable level discards the partial count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
        accept[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // On an accept, s2_q already holds the new level, so it gives the direction.
  always_comb begin
    captured = '0;
    case (EDGE_TYPE)
      0:       captured = accept & s2_q;
      1:       captured = accept & ~s2_q;
      default: captured = accept;
    endcase
  end

  // A hardware capture in the same cycle as a W1C of that bit keeps the bit set.
  always_comb begin
    w1c       = '0;
    irqmask_d = irqmask_q;
    if (wr_en && (address == ADDR_EDGE)) begin
      w1c = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_IRQMSK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~w1c) | captured;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= {WIDTH{IDLE_LEVEL}};
      s2_q      <= {WIDTH{IDLE_LEVEL}};
      stable_q  <= {WIDTH{IDLE_LEVEL}};
      cnt_q     <= '0;
      irqmask_q <= '0;
      edge_q    <= '0;
    end else begin
      s1_q      <= in_port;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      irqmask_q <= irqmask_d;
      edge_q    <= edge_d;
    end
  end

  // Read mux follows address regardless of chipselect; reads have no side effects.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = stable_q;
      ADDR_IRQMSK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGE:   readdata[WIDTH-1:0] = edge_q;
      default:     readdata = '0;
    endcase
  end

  // Derived purely from registers, so in_port has no combinational path to irq.
  assign irq = |(edge_q & irqmask_q);

endmodule
